// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial front end feeding the sequence FSM.
package serial_pkg;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } ser_state_t;

    localparam int unsigned SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; presents the output-end bit.
module piso_shift_reg
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_shift;

    // Load takes priority over shift; shifting moves the next bit to the output end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            if (MSB_FIRST) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end else begin
                r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            end
        end
    end

    assign o_bit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer with a one-word holding register for gapless streaming.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;

    logic             w_accept;
    logic             w_load;
    logic             w_shift;
    logic [WIDTH-1:0] w_load_data;
    logic             w_hold_wr;
    logic             w_hold_clr;
    logic             w_bit;

    assign load_ready = !r_hold_full && !rst;
    assign w_accept   = load_valid && load_ready;

    // Next-state, counter and datapath controls; done is decoded here from state and ser_en.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_load_data = data_in;
        w_hold_wr   = 1'b0;
        w_hold_clr  = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ser_en && (r_cnt == LAST)) begin
                    done = 1'b1;
                    if (r_hold_full) begin
                        w_load      = 1'b1;
                        w_load_data = r_hold;
                        w_hold_clr  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else if (w_accept) begin
                        // Hold is empty at the last-bit edge: the new word bypasses it.
                        w_load    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    if (ser_en) begin
                        w_shift   = 1'b1;
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    if (w_accept) begin
                        w_hold_wr = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bit counter within the current word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Holding register: filled while shifting, drained at the last-bit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_hold_wr) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
        end else if (w_hold_clr) begin
            r_hold_full <= 1'b0;
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_load_data),
        .o_bit   (w_bit)
    );

    assign ser_valid = (r_state == S_SHIFT);
    assign ser_out   = (r_state == S_SHIFT) ? w_bit : 1'b0;

endmodule
